axi_burst_sched: RTL and testbench

AXI_BURST_SCHED -- requirements
Module: axi_burst_sched

---
 rtl/axi_burst_sched_pkg.sv | 19 +
 rtl/axi_burst_sched_if.sv | 32 +++
 rtl/axi_burst_sched_rr_arbiter.sv | 29 ++
 rtl/axi_burst_sched.sv | 117 +++++++++++
 tb/tb_axi_burst_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_sched_pkg.sv
// Shared types and sizing helpers for the AXI line-burst scheduler.
// Holds the scheduler FSM state enum and the burst_ch width helper.
package axi_burst_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CH_DEFAULT = 2;
    localparam int CH_W_DEFAULT   = ch_width(NUM_CH_DEFAULT);

endpackage

// File: rtl/axi_burst_sched_if.sv
// Channel request and burst command signals of the scheduler.
// Handshakes: ch_req_valid is held until the one-cycle ch_req_ready pulse; a
// burst command transfers on the cycle where burst_valid and burst_ready are both high.
interface axi_burst_sched_if
    import axi_burst_sched_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0]            ch_req_valid;
    logic [NUM_CH-1:0]            ch_req_ready;
    logic [NUM_CH-1:0]            ch_frame_start;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_base_addr;
    logic                         burst_valid;
    logic                         burst_ready;
    logic [ADDR_WIDTH-1:0]        burst_addr;
    logic [CH_W-1:0]              burst_ch;
    logic                         burst_done;

    modport master (
        input  ch_req_valid, ch_frame_start, ch_base_addr, burst_ready, burst_done,
        output ch_req_ready, burst_valid, burst_addr, burst_ch
    );

    modport slave (
        output ch_req_valid, ch_frame_start, ch_base_addr, burst_ready, burst_done,
        input  ch_req_ready, burst_valid, burst_addr, burst_ch
    );

endinterface

// File: rtl/axi_burst_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    always_comb begin
        logic            found;
        logic [CH_W-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/axi_burst_sched.sv
// Shares one AXI read burst engine between NUM_CH video line readers, one burst in flight.
// Optional watchdog with sticky sched_err: define SCHED_TIMEOUT_EN.
module axi_burst_sched
    import axi_burst_sched_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_BYTES  = 7680,
    parameter int V_DISP      = 1080,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESET,
    axi_burst_sched_if.master   bus,
`ifdef SCHED_TIMEOUT_EN
    output logic                sched_err,
`endif
    output state_t              dbg_state
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam int LC_W = $clog2(V_DISP);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [LC_W-1:0]   line_cnt_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CH_W-1:0]   ch_q;
    logic              do_grant;
    logic [LC_W-1:0]   eff_line;
    logic [LC_W-1:0]   next_line;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [CH_W-1:0]   next_ptr;
    logic              wd_hit;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req   (bus.ch_req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Reset gates the grant so ch_req_ready drops the moment reset rises.
    assign do_grant = !M_AXI_ARESET && (state_q == IDLE) && (|bus.ch_req_valid);

    // A frame start in the grant cycle takes effect for the granted burst itself.
    always_comb begin
        eff_line   = bus.ch_frame_start[grant_idx] ? '0 : line_cnt_q[grant_idx];
        next_line  = (eff_line == LC_W'(V_DISP - 1)) ? '0 : eff_line + 1'b1;
        grant_addr = bus.ch_base_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH]
                   + ADDR_WIDTH'(eff_line) * ADDR_WIDTH'(LINE_BYTES);
        next_ptr   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (do_grant) state_d = ISSUE;
            ISSUE:     if (bus.burst_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.burst_done || wd_hit) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            ch_q     <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_CH; i++) line_cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (do_grant) begin
                addr_q   <= grant_addr;
                ch_q     <= grant_idx;
                rr_ptr_q <= next_ptr;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (do_grant && grant[i]) line_cnt_q[i] <= next_line;
                else if (bus.ch_frame_start[i]) line_cnt_q[i] <= '0;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q;

    assign wd_hit = (state_q == WAIT_DONE) && !bus.burst_done
                 && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            wd_cnt_q  <= '0;
            sched_err <= 1'b0;
        end else begin
            wd_cnt_q  <= (state_q == WAIT_DONE) ? wd_cnt_q + 1'b1 : '0;
            sched_err <= sched_err | wd_hit;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    assign bus.ch_req_ready = do_grant ? grant : '0;
    assign bus.burst_valid  = (state_q == ISSUE);
    assign bus.burst_addr   = addr_q;
    assign bus.burst_ch     = ch_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_axi_burst_sched.sv
// Randomized and directed bench for axi_burst_sched against a line-counter model.
// Build with SCHED_TIMEOUT_EN defined to include the watchdog scenario.
module tb_axi_burst_sched;
    import axi_burst_sched_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int LB  = 7680;
    localparam int VD  = 1080;
    localparam int TO  = 4096;
    localparam int CHW = ch_width(NCH);
    localparam int CW  = CHW + AW;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;
`ifdef SCHED_TIMEOUT_EN
    logic   sched_err;
`endif

    axi_burst_sched_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW)) bus();

    axi_burst_sched #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .LINE_BYTES(LB), .V_DISP(VD), .TIMEOUT_CYC(TO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (bus),
`ifdef SCHED_TIMEOUT_EN
        .sched_err    (sched_err),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0]  base [NCH];
    int             m_line [NCH];
    int             m_ptr;
    logic [CW-1:0]  exp_q [$];
    logic [NCH-1:0] req_hold;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < NCH; i++) m_line[i] = 0;
        m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic set_bases;
        for (int i = 0; i < NCH; i++) bus.ch_base_addr[i*AW +: AW] = base[i];
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        bus.ch_req_valid   = '0;
        bus.ch_frame_start = '0;
        bus.burst_ready    = 1'b0;
        bus.burst_done     = 1'b0;
        req_hold           = '0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        model_clear();
    endtask

    // ---------------- reference model ----------------
    // Round-robin from the pointer, per-channel line counter wrapping at V_DISP.
    task automatic model_grant(input logic [NCH-1:0] req, input logic [NCH-1:0] fs, output int g);
        int            eff;
        logic [AW-1:0] off;
        logic [31:0]   gv;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            logic [31:0] c;
            c = (m_ptr + k) % NCH;
            if (g < 0 && req[c[CHW-1:0]]) g = int'(c);
        end
        if (g < 0) return;
        gv  = g;
        eff = fs[gv[CHW-1:0]] ? 0 : m_line[g];
        off = AW'(eff * LB);
        exp_q.push_back({gv[CHW-1:0], base[g] + off});
        m_line[g] = (eff + 1) % VD;
        m_ptr     = (g + 1) % NCH;
        for (int i = 0; i < NCH; i++) if (i != g && fs[i]) m_line[i] = 0;
    endtask

    task automatic model_mid_fs(input logic [NCH-1:0] fs);
        for (int i = 0; i < NCH; i++) if (fs[i]) m_line[i] = 0;
    endtask

    // ---------------- driver ----------------
    // Caller sets ch_req_valid with the DUT in IDLE; returns with the DUT back in IDLE.
    task automatic drive_burst(input logic [NCH-1:0] fs, input int rdy_wait, input int done_wait,
                               input logic [NCH-1:0] mid_fs, input bit done_in_issue,
                               output logic [NCH-1:0] o_ready, output logic o_valid,
                               output logic [CW-1:0] o_cmd, output bit o_stable);
        bus.ch_frame_start = fs;
        #1;
        o_ready = bus.ch_req_ready;
        tick;
        bus.ch_frame_start = '0;
        bus.ch_req_valid   = (bus.ch_req_valid & ~o_ready) | req_hold;
        #1;
        o_valid  = bus.burst_valid;
        o_cmd    = {bus.burst_ch, bus.burst_addr};
        o_stable = 1'b1;
        for (int i = 0; i < rdy_wait; i++) begin
            bus.burst_done = done_in_issue && (i == 0);
            tick;
            bus.burst_done = 1'b0;
            #1;
            if (bus.burst_valid !== 1'b1 || {bus.burst_ch, bus.burst_addr} !== o_cmd
                || bus.ch_req_ready !== '0) o_stable = 1'b0;
        end
        bus.burst_ready = 1'b1;
        tick;
        bus.burst_ready    = 1'b0;
        bus.ch_frame_start = mid_fs;
        tick;
        bus.ch_frame_start = '0;
        repeat (done_wait) tick;
        bus.burst_done = 1'b1;
        tick;
        bus.burst_done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        bus.ch_req_valid   = '1;
        bus.ch_frame_start = '0;
        bus.burst_ready    = 1'b0;
        bus.burst_done     = 1'b0;
        #1 rst = 1'b1;
        tick;
        tick;
        #1;
        n_checks++; if (bus.ch_req_ready !== '0) $display("FAIL reset_ready got %b expected 0", bus.ch_req_ready); else n_pass++;
        n_checks++; if (bus.burst_valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", bus.burst_valid); else n_pass++;
        n_checks++; if (bus.burst_addr !== '0) $display("FAIL reset_addr got %h expected 0", bus.burst_addr); else n_pass++;
        n_checks++; if (bus.burst_ch !== '0) $display("FAIL reset_ch got %h expected 0", bus.burst_ch); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE); else n_pass++;
`ifdef SCHED_TIMEOUT_EN
        n_checks++; if (sched_err !== 1'b0) $display("FAIL reset_err got %b expected 0", sched_err); else n_pass++;
`endif
        bus.ch_req_valid = '0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic_addr;
        logic [NCH-1:0] rdy;
        logic           vld;
        logic [CW-1:0]  cmd;
        bit             stb;
        logic [AW-1:0]  want [2];
        want[0] = 32'h1000_0000;
        want[1] = 32'h1000_1E00;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            bus.ch_req_valid = 2'b01;
            drive_burst('0, 0, 2, '0, 1'b0, rdy, vld, cmd, stb);
            n_checks++; if (rdy !== 2'b01) $display("FAIL basic_ready[%0d] got %b expected 01", k, rdy); else n_pass++;
            n_checks++; if (vld !== 1'b1) $display("FAIL basic_latency[%0d] got valid %b expected 1", k, vld); else n_pass++;
            n_checks++; if (cmd !== {CHW'(0), want[k]}) $display("FAIL basic_cmd[%0d] got %h expected %h", k, cmd, {CHW'(0), want[k]}); else n_pass++;
        end
    endtask

    task automatic test_round_robin;
        logic [NCH-1:0] rdy;
        logic           vld;
        logic [CW-1:0]  cmd, exp;
        bit             stb;
        int             g;
        apply_reset();
        req_hold = 2'b11;
        bus.ch_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            model_grant(bus.ch_req_valid, '0, g);
            drive_burst('0, 0, 9, '0, 1'b0, rdy, vld, cmd, stb);
            exp = exp_q.pop_front();
            n_checks++; if (cmd[AW +: CHW] !== CHW'(k % 2)) $display("FAIL rr_order[%0d] got ch %0d expected %0d", k, cmd[AW +: CHW], k % 2); else n_pass++;
            n_checks++; if (cmd !== exp) $display("FAIL rr_cmd[%0d] got %h expected %h", k, cmd, exp); else n_pass++;
        end
        req_hold = '0;
        bus.ch_req_valid = '0;
    endtask

    task automatic test_ready_stall;
        logic [NCH-1:0] rdy;
        logic           vld;
        logic [CW-1:0]  cmd, exp;
        bit             stb;
        int             g;
        apply_reset();
        req_hold = 2'b11;
        bus.ch_req_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            model_grant(bus.ch_req_valid, '0, g);
            drive_burst('0, (k == 0) ? 20 : 0, 2, '0, 1'b1, rdy, vld, cmd, stb);
            exp = exp_q.pop_front();
            n_checks++; if (stb !== 1'b1) $display("FAIL stall_stable[%0d] got %b expected 1", k, stb); else n_pass++;
            n_checks++; if (cmd !== exp) $display("FAIL stall_cmd[%0d] got %h expected %h", k, cmd, exp); else n_pass++;
        end
        req_hold = '0;
        bus.ch_req_valid = '0;
    endtask

    task automatic test_frame_start_grant;
        logic [NCH-1:0] rdy;
        logic           vld;
        logic [CW-1:0]  cmd, exp;
        bit             stb;
        int             g, errs;
        apply_reset();
        errs = 0;
        for (int k = 0; k < 500; k++) begin
            bus.ch_req_valid = 2'b10;
            model_grant(bus.ch_req_valid, '0, g);
            drive_burst('0, 0, 0, '0, 1'b0, rdy, vld, cmd, stb);
            exp = exp_q.pop_front();
            n_checks++; if (cmd !== exp) $display("FAIL fs_warmup[%0d] got %h expected %h", k, cmd, exp); else n_pass++;
        end
        bus.ch_req_valid = 2'b10;
        model_grant(bus.ch_req_valid, 2'b10, g);
        drive_burst(2'b10, 0, 0, '0, 1'b0, rdy, vld, cmd, stb);
        exp = exp_q.pop_front();
        n_checks++; if (cmd !== {CHW'(1), base[1]}) $display("FAIL fs_grant got %h expected %h", cmd, {CHW'(1), base[1]}); else n_pass++;
        bus.ch_req_valid = 2'b10;
        model_grant(bus.ch_req_valid, '0, g);
        drive_burst('0, 0, 0, '0, 1'b0, rdy, vld, cmd, stb);
        exp = exp_q.pop_front();
        n_checks++; if (cmd !== {CHW'(1), base[1] + AW'(LB)}) $display("FAIL fs_next got %h expected %h", cmd, {CHW'(1), base[1] + AW'(LB)}); else n_pass++;
    endtask

    task automatic test_line_wrap;
        logic [NCH-1:0] rdy;
        logic           vld;
        logic [CW-1:0]  cmd, exp;
        bit             stb;
        int             g;
        apply_reset();
        for (int k = 0; k < VD; k++) begin
            bus.ch_req_valid = 2'b01;
            model_grant(bus.ch_req_valid, '0, g);
            drive_burst('0, 0, 0, '0, 1'b0, rdy, vld, cmd, stb);
            exp = exp_q.pop_front();
            n_checks++; if (cmd !== exp) $display("FAIL wrap_line[%0d] got %h expected %h", k, cmd, exp); else n_pass++;
        end
        bus.ch_req_valid = 2'b01;
        model_grant(bus.ch_req_valid, '0, g);
        drive_burst('0, 0, 0, '0, 1'b0, rdy, vld, cmd, stb);
        exp = exp_q.pop_front();
        n_checks++; if (cmd !== {CHW'(0), base[0]}) $display("FAIL wrap_line0 got %h expected %h", cmd, {CHW'(0), base[0]}); else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        logic [NCH-1:0] rdy;
        logic           vld;
        logic [CW-1:0]  cmd, exp;
        bit             stb;
        int             g;
        apply_reset();
        bus.ch_req_valid = 2'b01;
        tick;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.burst_valid !== 1'b0) $display("FAIL midrst_valid got %b expected 0", bus.burst_valid); else n_pass++;
        n_checks++; if (bus.burst_addr !== '0) $display("FAIL midrst_addr got %h expected 0", bus.burst_addr); else n_pass++;
        n_checks++; if (bus.ch_req_ready !== '0) $display("FAIL midrst_ready got %b expected 0", bus.ch_req_ready); else n_pass++;
        bus.ch_req_valid = '0;
        tick;
        rst = 1'b0;
        model_clear();
        tick;
        bus.burst_done = 1'b1;
        tick;
        bus.burst_done = 1'b0;
        #1;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL stale_done_state got %0d expected %0d", dbg_state, IDLE); else n_pass++;
        bus.ch_req_valid = 2'b01;
        model_grant(bus.ch_req_valid, '0, g);
        drive_burst('0, 1, 1, '0, 1'b0, rdy, vld, cmd, stb);
        exp = exp_q.pop_front();
        n_checks++; if (cmd !== exp) $display("FAIL midrst_next got %h expected %h", cmd, exp); else n_pass++;
    endtask

    task automatic test_random;
        logic [NCH-1:0] rdy, req, fs, mid;
        logic           vld;
        logic [CW-1:0]  cmd, exp;
        bit             stb;
        int             g;
        apply_reset();
        for (int i = 0; i < NCH; i++) base[i] = $urandom();
        set_bases();
        for (int k = 0; k < 200; k++) begin
            req = NCH'($urandom_range(1, (1 << NCH) - 1));
            fs  = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0;
            mid = ($urandom_range(0, 4) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0;
            bus.ch_req_valid = req;
            model_grant(req, fs, g);
            drive_burst(fs, $urandom_range(0, 3), $urandom_range(0, 4), mid, 1'b0, rdy, vld, cmd, stb);
            model_mid_fs(mid);
            exp = exp_q.pop_front();
            n_checks++; if (rdy !== NCH'(1 << g)) $display("FAIL rand_ready[%0d] got %b expected %b", k, rdy, NCH'(1 << g)); else n_pass++;
            n_checks++; if (cmd !== exp) $display("FAIL rand_cmd[%0d] got %h expected %h", k, cmd, exp); else n_pass++;
        end
        bus.ch_req_valid = '0;
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        apply_reset();
        bus.ch_req_valid = 2'b01;
        tick;
        bus.ch_req_valid = '0;
        bus.burst_ready  = 1'b1;
        tick;
        bus.burst_ready  = 1'b0;
        n = 0;
        while (dbg_state == WAIT_DONE && n < TO + 100) begin
            tick;
            n++;
        end
        #1;
        n_checks++; if (n !== TO) $display("FAIL timeout_cycles got %0d expected %0d", n, TO); else n_pass++;
        n_checks++; if (sched_err !== 1'b1) $display("FAIL timeout_err got %b expected 1", sched_err); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL timeout_state got %0d expected %0d", dbg_state, IDLE); else n_pass++;
        bus.ch_req_valid = 2'b01;
        #1;
        n_checks++; if (bus.ch_req_ready !== 2'b01) $display("FAIL timeout_regrant got %b expected 01", bus.ch_req_ready); else n_pass++;
        tick;
        bus.ch_req_valid = '0;
        #1;
        n_checks++; if (bus.burst_valid !== 1'b1) $display("FAIL timeout_valid got %b expected 1", bus.burst_valid); else n_pass++;
        n_checks++; if (sched_err !== 1'b1) $display("FAIL timeout_sticky got %b expected 1", sched_err); else n_pass++;
    endtask
`endif

    initial begin
        base[0] = 32'h1000_0000;
        base[1] = 32'h2000_0000;
        set_bases();
        req_hold = '0;
        model_clear();
        test_reset();
        test_basic_addr();
        test_round_robin();
        test_ready_stall();
        test_frame_start_grant();
        test_line_wrap();
        test_reset_mid_burst();
        test_random();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
